// File: rtl/cube_pkg.sv
// Shared definitions for the LED cube scan driver.
//   scan_state_t : scan sequencer states
//   lane_index   : maps (panel, color) to the serial lane / pixel-word lane
//   addr_width   : frame memory address width for a ROWS x COLS panel
//   win_width    : width of the BCM display-window counter
//   BRIGHT_W     : width of the global brightness value
//   BRIGHT_FRAC  : brightness is a fraction of 256, so on-times are >> BRIGHT_FRAC
package cube_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREP,
        ST_SHIFT,
        ST_LATCH,
        ST_DISPLAY,
        ST_BLANK
    } scan_state_t;

    localparam int BRIGHT_W    = 8;
    localparam int BRIGHT_FRAC = 8;

    function automatic int lane_index(input int panel, input int color, input int num_colors);
        return panel * num_colors + color;
    endfunction

    function automatic int addr_width(input int rows, input int cols);
        return $clog2(rows) + $clog2(cols);
    endfunction

    // Longest window is BASE_TICKS << (BIT_DEPTH-1), which fits in this many bits.
    function automatic int win_width(input int base_ticks, input int bit_depth);
        return $clog2(base_ticks) + bit_depth;
    endfunction

endpackage

// File: rtl/bcm_window_timer.sv
// Binary-code-modulation display window timer.
// A start pulse opens a window of W = BASE_TICKS << plane cycles; on_active is
// high for the first (W * brightness_latched) >> 8 cycles of it and
// window_done marks the last cycle of the window.
//   clk, reset         : clock, asynchronous active-high reset
//   start              : one-cycle pulse, window begins on the following cycle
//   plane              : bit plane being displayed (selects W)
//   brightness_latched : global brightness for the current frame
//   on_active          : drive outputs during this cycle of the window
//   window_done        : this is the final cycle of the window
module bcm_window_timer
    import cube_pkg::*;
#(
    parameter int BASE_TICKS = 8,
    parameter int BIT_DEPTH  = 8,
    parameter int PLANE_W    = $clog2(BIT_DEPTH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [PLANE_W-1:0]  plane,
    input  logic [BRIGHT_W-1:0] brightness_latched,
    output logic                on_active,
    output logic                window_done
);

    localparam int WIN_W  = win_width(BASE_TICKS, BIT_DEPTH);
    localparam int PROD_W = WIN_W + BRIGHT_W;

    logic [WIN_W-1:0]  window_len;
    logic [WIN_W-1:0]  on_len;
    logic [PROD_W-1:0] product;
    logic [WIN_W-1:0]  cnt_q, cnt_d;
    logic              running_q, running_d;

    // The multiply is done at full width before the shift so no on-time
    // precision is lost for long windows.
    always_comb begin
        window_len  = WIN_W'(BASE_TICKS) << plane;
        product     = PROD_W'(window_len) * PROD_W'(brightness_latched);
        on_len      = WIN_W'(product >> BRIGHT_FRAC);
        window_done = running_q && (cnt_q == window_len - 1'b1);
        on_active   = running_q && (cnt_q < on_len);

        cnt_d     = cnt_q;
        running_d = running_q;
        if (start) begin
            cnt_d     = '0;
            running_d = 1'b1;
        end else if (running_q) begin
            if (window_done) begin
                cnt_d     = '0;
                running_d = 1'b0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            running_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            running_q <= running_d;
        end
    end

endmodule

// File: rtl/led_panel_scan_driver.sv
// LED panel scan driver: reads pixel words from frame memory, shifts one bit
// plane per row into NUM_PANELS x NUM_COLORS serial chains, latches it and
// drives the row for a BCM window scaled by a per-frame brightness, followed
// by a blanking gap.
//   clk, reset        : clock, asynchronous active-high reset
//   enable            : run scanning (checked in IDLE and at the end of BLANK)
//   brightness        : global dimming, captured at the start of each frame
//   rd_addr / rd_data : frame memory port {row, col}, data one cycle later
//   serial_clk        : shift clock, data stable across its rising edge
//   serial_data_out   : current plane bit of each lane
//   latch_enable      : one-cycle latch pulse per plane
//   output_enable_n   : active-low drive enable
//   row_select_n      : one-cold row drive
//   frame_done        : pulse after the last plane of the last row
module led_panel_scan_driver
    import cube_pkg::*;
#(
    parameter int NUM_PANELS   = 4,
    parameter int NUM_COLORS   = 3,
    parameter int ROWS         = 16,
    parameter int COLS         = 16,
    parameter int BIT_DEPTH    = 8,
    parameter int BASE_TICKS   = 8,
    parameter int BLANK_CYCLES = 4
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        enable,
    input  logic [7:0]                                  brightness,
    output logic [$clog2(ROWS)+$clog2(COLS)-1:0]        rd_addr,
    input  logic [NUM_PANELS*NUM_COLORS*BIT_DEPTH-1:0]  rd_data,
    output logic                                        serial_clk,
    output logic                                        latch_enable,
    output logic                                        output_enable_n,
    output logic [NUM_PANELS*NUM_COLORS-1:0]            serial_data_out,
    output logic [ROWS-1:0]                             row_select_n,
    output logic                                        frame_done
);

    localparam int NUM_LANES = NUM_PANELS * NUM_COLORS;
    localparam int ROW_W     = $clog2(ROWS);
    localparam int COL_W     = $clog2(COLS);
    localparam int ADDR_W    = addr_width(ROWS, COLS);
    localparam int PLANE_W   = $clog2(BIT_DEPTH);
    localparam int BLANK_W   = $clog2(BLANK_CYCLES + 1);

    localparam logic [ROW_W-1:0]   LAST_ROW   = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0]   LAST_COL   = COL_W'(COLS - 1);
    localparam logic [PLANE_W-1:0] LAST_PLANE = PLANE_W'(BIT_DEPTH - 1);
    localparam logic [BLANK_W-1:0] LAST_BLANK = BLANK_W'(BLANK_CYCLES - 1);

    scan_state_t state_q, state_d;
    logic [ROW_W-1:0]     row_q, row_d;
    logic [COL_W-1:0]     col_q, col_d;
    logic [PLANE_W-1:0]   plane_q, plane_d;
    logic                 phase_q, phase_d;
    logic [BLANK_W-1:0]   blank_cnt_q, blank_cnt_d;
    logic [BRIGHT_W-1:0]  bright_q, bright_d;

    logic                 serial_clk_q, serial_clk_d;
    logic                 latch_q, latch_d;
    logic                 oe_n_q, oe_n_d;
    logic [NUM_LANES-1:0] sdo_q, sdo_d;
    logic [ROWS-1:0]      row_sel_q, row_sel_d;
    logic [ADDR_W-1:0]    rd_addr_q, rd_addr_d;
    logic                 frame_done_q, frame_done_d;

    logic [NUM_LANES-1:0] lane_bits;
    logic                 frame_end;
    logic                 window_start;
    logic                 on_active;
    logic                 window_done;

    bcm_window_timer #(
        .BASE_TICKS (BASE_TICKS),
        .BIT_DEPTH  (BIT_DEPTH),
        .PLANE_W    (PLANE_W)
    ) u_timer (
        .clk                (clk),
        .reset              (reset),
        .start              (window_start),
        .plane              (plane_q),
        .brightness_latched (bright_q),
        .on_active          (on_active),
        .window_done        (window_done)
    );

    // Pick the current plane bit out of every lane of the pixel word.
    always_comb begin
        lane_bits = '0;
        for (int p = 0; p < NUM_PANELS; p++) begin
            for (int c = 0; c < NUM_COLORS; c++) begin
                lane_bits[lane_index(p, c, NUM_COLORS)] =
                    rd_data[lane_index(p, c, NUM_COLORS) * BIT_DEPTH + int'(plane_q)];
            end
        end
    end

    // Sequencer. The memory address is issued one step ahead of the shift so
    // that read data is back in time; the pin outputs are registered from the
    // current state and therefore trail it by one cycle as a group.
    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        plane_d      = plane_q;
        phase_d      = phase_q;
        blank_cnt_d  = blank_cnt_q;
        bright_d     = bright_q;
        rd_addr_d    = rd_addr_q;
        frame_end    = 1'b0;
        window_start = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_PREP;
                    row_d   = '0;
                    plane_d = '0;
                end
            end
            ST_PREP: begin
                state_d = ST_SHIFT;
                col_d   = LAST_COL;
                phase_d = 1'b0;
            end
            ST_SHIFT: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                    if (col_q != '0) begin
                        rd_addr_d = {row_q, col_q - 1'b1};
                    end
                end else begin
                    phase_d = 1'b0;
                    if (col_q == '0) begin
                        state_d = ST_LATCH;
                    end else begin
                        col_d = col_q - 1'b1;
                    end
                end
            end
            ST_LATCH: begin
                state_d      = ST_DISPLAY;
                window_start = 1'b1;
            end
            ST_DISPLAY: begin
                if (window_done) begin
                    state_d     = ST_BLANK;
                    blank_cnt_d = '0;
                end
            end
            ST_BLANK: begin
                if (blank_cnt_q == LAST_BLANK) begin
                    if (plane_q == LAST_PLANE) begin
                        plane_d = '0;
                        if (row_q == LAST_ROW) begin
                            row_d     = '0;
                            frame_end = 1'b1;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        plane_d = plane_q + 1'b1;
                    end
                    if (enable) begin
                        state_d = ST_PREP;
                    end else begin
                        state_d = ST_IDLE;
                        row_d   = '0;
                        plane_d = '0;
                    end
                end else begin
                    blank_cnt_d = blank_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Entering PREP: point at the first column; a new frame also
        // captures brightness so it never changes part way through a frame.
        if (state_d == ST_PREP && state_q != ST_PREP) begin
            rd_addr_d = {row_d, LAST_COL};
            if (row_d == '0 && plane_d == '0) begin
                bright_d = brightness;
            end
        end

        serial_clk_d = (state_q == ST_SHIFT) && phase_q;
        sdo_d        = '0;
        if (state_q == ST_SHIFT) begin
            sdo_d = phase_q ? sdo_q : lane_bits;
        end
        latch_d      = (state_q == ST_LATCH);
        oe_n_d       = !((state_q == ST_DISPLAY) && on_active);
        frame_done_d = frame_end;
        row_sel_d    = row_sel_q;
        if (state_q == ST_IDLE) begin
            row_sel_d = '1;
        end else if (state_q == ST_LATCH) begin
            row_sel_d = ~(ROWS'(1) << row_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            row_q        <= '0;
            col_q        <= '0;
            plane_q      <= '0;
            phase_q      <= 1'b0;
            blank_cnt_q  <= '0;
            bright_q     <= '0;
            serial_clk_q <= 1'b0;
            latch_q      <= 1'b0;
            oe_n_q       <= 1'b1;
            sdo_q        <= '0;
            row_sel_q    <= '1;
            rd_addr_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            plane_q      <= plane_d;
            phase_q      <= phase_d;
            blank_cnt_q  <= blank_cnt_d;
            bright_q     <= bright_d;
            serial_clk_q <= serial_clk_d;
            latch_q      <= latch_d;
            oe_n_q       <= oe_n_d;
            sdo_q        <= sdo_d;
            row_sel_q    <= row_sel_d;
            rd_addr_q    <= rd_addr_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign rd_addr         = rd_addr_q;
    assign serial_clk      = serial_clk_q;
    assign latch_enable    = latch_q;
    assign output_enable_n = oe_n_q;
    assign serial_data_out = sdo_q;
    assign row_select_n    = row_sel_q;
    assign frame_done      = frame_done_q;

endmodule

// File: tb/tb_led_panel_scan_driver.sv
// Testbench for led_panel_scan_driver in a small configuration.
// A behavioural model predicts, for every latched plane, the bits shifted out,
// the row driven and the number of output-enable cycles, and the frame period.
module tb_led_panel_scan_driver;

    localparam int NP     = 1;
    localparam int NC     = 3;
    localparam int ROWS   = 2;
    localparam int COLS   = 4;
    localparam int BD     = 2;
    localparam int BASE   = 4;
    localparam int BLANKC = 2;
    localparam int NL     = NP * NC;
    localparam int DW     = NL * BD;
    localparam int AW     = $clog2(ROWS) + $clog2(COLS);
    localparam int SW     = NL * COLS;
    localparam int FRAME_CYC = ROWS * (BD * (2 + 2 * COLS + BLANKC) + BASE * ((1 << BD) - 1));

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            enable = 1'b0;
    logic [7:0]      brightness = 8'd0;
    logic [AW-1:0]   rd_addr;
    logic [DW-1:0]   rd_data;
    logic            serial_clk;
    logic            latch_enable;
    logic            output_enable_n;
    logic [NL-1:0]   serial_data_out;
    logic [ROWS-1:0] row_select_n;
    logic            frame_done;

    logic [DW-1:0]   mem [ROWS*COLS];

    int pass_cnt = 0;
    int check_cnt = 0;

    // Monitor state
    int            cyc;
    logic          prev_sck;
    int            cur_rises, cur_on;
    logic [SW-1:0] cur_bits;
    bit            open_rec;
    int            q_rises[$];
    logic [SW-1:0] q_bits[$];
    logic [ROWS-1:0] q_rowsel[$];
    int            q_on[$];
    int            fd_cyc[$];

    led_panel_scan_driver #(
        .NUM_PANELS   (NP),
        .NUM_COLORS   (NC),
        .ROWS         (ROWS),
        .COLS         (COLS),
        .BIT_DEPTH    (BD),
        .BASE_TICKS   (BASE),
        .BLANK_CYCLES (BLANKC)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .brightness      (brightness),
        .rd_addr         (rd_addr),
        .rd_data         (rd_data),
        .serial_clk      (serial_clk),
        .latch_enable    (latch_enable),
        .output_enable_n (output_enable_n),
        .serial_data_out (serial_data_out),
        .row_select_n    (row_select_n),
        .frame_done      (frame_done)
    );

    always #5 clk = ~clk;

    // Frame memory with one cycle of read latency
    always @(posedge clk) rd_data <= mem[rd_addr];

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Expected shift stream for one plane: columns high to low, each column
    // contributing lanes NL-1..0 as one group, first column most significant.
    function automatic logic [SW-1:0] exp_bits(input int r, input int b);
        int v = 0;
        for (int c = COLS - 1; c >= 0; c--)
            for (int l = NL - 1; l >= 0; l--)
                v = v * 2 + ((int'(mem[r*COLS+c]) >> (l * BD + b)) & 1);
        return SW'(v);
    endfunction

    function automatic int exp_on(input int b, input int br);
        return ((BASE << b) * br) >> 8;
    endfunction

    function automatic logic [ROWS-1:0] exp_rowsel(input int r);
        logic [ROWS-1:0] one = 1;
        return ~(one << r);
    endfunction

    task automatic clear_mon();
        cur_rises = 0; cur_on = 0; cur_bits = '0; open_rec = 0; prev_sck = 1'b0;
        q_rises.delete(); q_bits.delete(); q_rowsel.delete(); q_on.delete(); fd_cyc.delete();
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        if (serial_clk && !prev_sck) begin
            cur_rises++;
            cur_bits = (cur_bits << NL) | SW'(serial_data_out);
        end
        prev_sck = serial_clk;
        if (!output_enable_n) cur_on++;
        if (latch_enable) begin
            if (open_rec) q_on.push_back(cur_on);
            q_rises.push_back(cur_rises);
            q_bits.push_back(cur_bits);
            q_rowsel.push_back(row_select_n);
            cur_rises = 0; cur_bits = '0; cur_on = 0; open_rec = 1;
        end
        if (frame_done) fd_cyc.push_back(cyc);
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic flush();
        if (open_rec) begin
            q_on.push_back(cur_on);
            open_rec = 0;
        end
    endtask

    task automatic applyStimulus(input int br, input bit random_mem);
        enable = 1'b0;
        reset = 1'b1;
        if (random_mem)
            for (int i = 0; i < ROWS * COLS; i++) mem[i] = DW'($urandom);
        steps(2);
        reset = 1'b0;
        clear_mon();
        brightness = 8'(br);
        enable = 1'b1;
    endtask

    task automatic test_reset();
        step();
        #1 reset = 1'b1;
        #1;
        check_cnt++; if (output_enable_n !== 1'b1) $display("[TB] FAIL reset_oe_n got %b want 1", output_enable_n); else pass_cnt++;
        check_cnt++; if (row_select_n !== 2'b11) $display("[TB] FAIL reset_row_sel got %b want 11", row_select_n); else pass_cnt++;
        check_cnt++; if (serial_clk !== 1'b0) $display("[TB] FAIL reset_sclk got %b want 0", serial_clk); else pass_cnt++;
        check_cnt++; if (latch_enable !== 1'b0) $display("[TB] FAIL reset_latch got %b want 0", latch_enable); else pass_cnt++;
        check_cnt++; if (serial_data_out !== '0) $display("[TB] FAIL reset_sdo got %b want 0", serial_data_out); else pass_cnt++;
        check_cnt++; if (rd_addr !== '0) $display("[TB] FAIL reset_rd_addr got %0d want 0", rd_addr); else pass_cnt++;
        check_cnt++; if (frame_done !== 1'b0) $display("[TB] FAIL reset_frame_done got %b want 0", frame_done); else pass_cnt++;
        steps(2);
        reset = 1'b0;
    endtask

    task automatic test_full_brightness();
        applyStimulus(255, 1);
        steps(2 * FRAME_CYC + 30);
        flush();
        check_cnt++;
        if (q_rises.size() < 2 * ROWS * BD + 1)
            $display("[TB] FAIL full_plane_count got %0d want >=%0d", q_rises.size(), 2 * ROWS * BD + 1);
        else begin
            pass_cnt++;
            for (int i = 0; i < 2 * ROWS * BD; i++) begin
                int r = (i / BD) % ROWS;
                int b = i % BD;
                check_cnt++; if (q_rises[i] !== COLS) $display("[TB] FAIL full_rises[%0d] got %0d want %0d", i, q_rises[i], COLS); else pass_cnt++;
                check_cnt++; if (q_bits[i] !== exp_bits(r, b)) $display("[TB] FAIL full_bits[%0d] got %h want %h", i, q_bits[i], exp_bits(r, b)); else pass_cnt++;
                check_cnt++; if (q_rowsel[i] !== exp_rowsel(r)) $display("[TB] FAIL full_rowsel[%0d] got %b want %b", i, q_rowsel[i], exp_rowsel(r)); else pass_cnt++;
                check_cnt++; if (q_on[i] !== exp_on(b, 255)) $display("[TB] FAIL full_on[%0d] got %0d want %0d", i, q_on[i], exp_on(b, 255)); else pass_cnt++;
            end
        end
        check_cnt++;
        if (fd_cyc.size() < 2)
            $display("[TB] FAIL frame_done_count got %0d want >=2", fd_cyc.size());
        else if (fd_cyc[1] - fd_cyc[0] !== FRAME_CYC)
            $display("[TB] FAIL frame_period got %0d want %0d", fd_cyc[1] - fd_cyc[0], FRAME_CYC);
        else pass_cnt++;
    endtask

    task automatic test_single_bit();
        for (int i = 0; i < ROWS * COLS; i++) mem[i] = '0;
        mem[COLS-1] = DW'(1);
        applyStimulus(255, 0);
        steps(FRAME_CYC + 20);
        flush();
        check_cnt++;
        if (q_bits.size() < ROWS * BD)
            $display("[TB] FAIL single_plane_count got %0d want >=%0d", q_bits.size(), ROWS * BD);
        else begin
            pass_cnt++;
            for (int i = 0; i < ROWS * BD; i++) begin
                check_cnt++;
                if (q_bits[i] !== exp_bits((i / BD) % ROWS, i % BD))
                    $display("[TB] FAIL single_bits[%0d] got %h want %h", i, q_bits[i], exp_bits((i / BD) % ROWS, i % BD));
                else pass_cnt++;
            end
            check_cnt++; if (q_bits[0] !== 12'h200) $display("[TB] FAIL single_first_bit got %h want 200", q_bits[0]); else pass_cnt++;
            check_cnt++; if ((q_bits[1] & 12'h249) !== 12'h000) $display("[TB] FAIL single_plane1_lane0 got %h want 000", q_bits[1] & 12'h249); else pass_cnt++;
        end
    endtask

    task automatic test_zero_brightness();
        int guard = 0;
        int total_on;
        applyStimulus(0, 1);
        while (fd_cyc.size() == 0 && guard < 4 * FRAME_CYC) begin
            step();
            guard++;
        end
        check_cnt++;
        if (fd_cyc.size() == 0) $display("[TB] FAIL zero_frame_done_timeout got 0 pulses want 1"); else pass_cnt++;
        flush();
        total_on = 0;
        foreach (q_on[i]) total_on += q_on[i];
        check_cnt++; if (total_on !== 0) $display("[TB] FAIL zero_oe_low_cycles got %0d want 0", total_on); else pass_cnt++;
        check_cnt++; if (q_rises.size() !== ROWS * BD) $display("[TB] FAIL zero_latch_count got %0d want %0d", q_rises.size(), ROWS * BD); else pass_cnt++;
    endtask

    task automatic test_brightness_change();
        applyStimulus(0, 1);
        steps(30);
        brightness = 8'd128;
        steps(2 * FRAME_CYC + 30);
        flush();
        check_cnt++;
        if (q_on.size() < 2 * ROWS * BD)
            $display("[TB] FAIL bchg_plane_count got %0d want >=%0d", q_on.size(), 2 * ROWS * BD);
        else begin
            pass_cnt++;
            for (int i = 0; i < 2 * ROWS * BD; i++) begin
                int br = (i < ROWS * BD) ? 0 : 128;
                check_cnt++;
                if (q_on[i] !== exp_on(i % BD, br))
                    $display("[TB] FAIL bchg_on[%0d] got %0d want %0d", i, q_on[i], exp_on(i % BD, br));
                else pass_cnt++;
            end
            check_cnt++; if (q_on[2*ROWS*BD-1] !== 4) $display("[TB] FAIL bchg_plane1_on got %0d want 4", q_on[2*ROWS*BD-1]); else pass_cnt++;
        end
    endtask

    task automatic test_enable_drop();
        int guard = 0;
        applyStimulus(255, 1);
        while (rd_addr[AW-1] !== 1'b1 && guard < 2 * FRAME_CYC) begin
            step();
            guard++;
        end
        check_cnt++;
        if (rd_addr[AW-1] !== 1'b1) $display("[TB] FAIL drop_row1_timeout got row %b want 1", rd_addr[AW-1]); else pass_cnt++;
        steps(3);
        enable = 1'b0;
        steps(60);
        flush();
        check_cnt++;
        if (q_rises.size() !== BD + 1)
            $display("[TB] FAIL drop_latch_count got %0d want %0d", q_rises.size(), BD + 1);
        else begin
            pass_cnt++;
            check_cnt++; if (q_rises[BD] !== COLS) $display("[TB] FAIL drop_last_rises got %0d want %0d", q_rises[BD], COLS); else pass_cnt++;
            check_cnt++; if (q_on[BD] !== exp_on(0, 255)) $display("[TB] FAIL drop_last_on got %0d want %0d", q_on[BD], exp_on(0, 255)); else pass_cnt++;
            check_cnt++; if (q_rowsel[BD] !== exp_rowsel(1)) $display("[TB] FAIL drop_last_row got %b want %b", q_rowsel[BD], exp_rowsel(1)); else pass_cnt++;
        end
        check_cnt++; if (fd_cyc.size() !== 0) $display("[TB] FAIL drop_frame_done got %0d pulses want 0", fd_cyc.size()); else pass_cnt++;
        check_cnt++; if (row_select_n !== 2'b11) $display("[TB] FAIL drop_idle_row_sel got %b want 11", row_select_n); else pass_cnt++;
        check_cnt++; if (output_enable_n !== 1'b1) $display("[TB] FAIL drop_idle_oe_n got %b want 1", output_enable_n); else pass_cnt++;
    endtask

    task automatic checkOutput_reset_mid_display();
        int guard = 0;
        applyStimulus(255, 1);
        while (output_enable_n !== 1'b0 && guard < 2 * FRAME_CYC) begin
            step();
            guard++;
        end
        check_cnt++;
        if (output_enable_n !== 1'b0) $display("[TB] FAIL midrst_display_timeout got oe_n %b want 0", output_enable_n); else pass_cnt++;
        #2 reset = 1'b1;
        #1;
        check_cnt++; if (output_enable_n !== 1'b1) $display("[TB] FAIL midrst_oe_n got %b want 1", output_enable_n); else pass_cnt++;
        check_cnt++; if (row_select_n !== 2'b11) $display("[TB] FAIL midrst_row_sel got %b want 11", row_select_n); else pass_cnt++;
        steps(2);
        reset = 1'b0;
        clear_mon();
        steps(40);
        flush();
        check_cnt++;
        if (q_rises.size() < 1)
            $display("[TB] FAIL midrst_restart_latches got 0 want >=1");
        else begin
            pass_cnt++;
            check_cnt++; if (q_rowsel[0] !== exp_rowsel(0)) $display("[TB] FAIL midrst_row got %b want %b", q_rowsel[0], exp_rowsel(0)); else pass_cnt++;
            check_cnt++; if (q_bits[0] !== exp_bits(0, 0)) $display("[TB] FAIL midrst_bits got %h want %h", q_bits[0], exp_bits(0, 0)); else pass_cnt++;
            check_cnt++; if (q_on[0] !== exp_on(0, 255)) $display("[TB] FAIL midrst_on got %0d want %0d", q_on[0], exp_on(0, 255)); else pass_cnt++;
        end
    endtask

    initial begin
        cyc = 0;
        clear_mon();
        for (int i = 0; i < ROWS * COLS; i++) mem[i] = '0;
        test_reset();
        test_full_brightness();
        test_single_bit();
        test_zero_brightness();
        test_brightness_change();
        test_enable_drop();
        checkOutput_reset_mid_display();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/led_panel_scan_driver.md
Name: led_panel_scan_driver

Overview:
Parametrised successor to the fixed 4-panel/3-colour cube scan controller. Reads pixel words from an external frame memory and shifts one bit plane per row into NUM_PANELS x NUM_COLORS serial chains. It then latches the plane and drives rows with binary-code-modulated (BCM) on-times, scaled by a global brightness, with a blanking gap between planes. Sits between the frame buffer and the cube GPIO pins; frame_done lets an upstream double-buffer swap on frame boundaries.

Parameters:
NUM_PANELS, 4, independent shift-chain groups.
NUM_COLORS, 3, colour channels per panel.
ROWS, 16, multiplexed rows (row_select_n width).
COLS, 16, bits per shift chain per row.
BIT_DEPTH, 8, intensity bits per channel (BCM planes).
BASE_TICKS, 8, clk cycles in the plane-0 display window (power of two, >=2).
BLANK_CYCLES, 4, output-off cycles after each display window (>=1).

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous, active-high reset.
enable  in  1  run scanning; sampled only in IDLE and at the end of BLANK.
brightness  in  8  global dimming; latched once per frame.
rd_addr  out  clog2(ROWS)+clog2(COLS)  frame memory address {row, col}.
rd_data  in  NUM_PANELS*NUM_COLORS*BIT_DEPTH  pixel word, valid 1 cycle after rd_addr. Lane L = p*NUM_COLORS+c occupies bits [(L+1)*BIT_DEPTH-1 : L*BIT_DEPTH].
serial_clk  out  1  shift clock to the panel drivers.
latch_enable  out  1  one-cycle latch pulse.
output_enable_n  out  1  active-low drive enable.
serial_data_out  out  NUM_PANELS*NUM_COLORS  bit L = current plane bit of lane L.
row_select_n  out  ROWS  one-cold row drive.
frame_done  out  1  one-cycle pulse at the end of the last plane of the last row.

Behaviour:
- Reset (async, immediate): state IDLE, row=0, plane=0, serial_clk=0, latch_enable=0, output_enable_n=1, serial_data_out=0, row_select_n=all 1, rd_addr=0, frame_done=0.
- States: IDLE, PREP, SHIFT, LATCH, DISPLAY, BLANK. All outputs are registered.
- IDLE: output_enable_n=1, row_select_n=all 1. If enable=1, go to PREP with row=0 and plane=0.
- Brightness is latched on PREP entry when row=0 and plane=0. Mid-frame changes take effect on the next frame.
- PREP (1 cycle): rd_addr={row, COLS-1}, then SHIFT.
- SHIFT: 2 cycles per column; columns go out in descending order (COLS-1 first).
  - Phase 0: serial_clk=0; serial_data_out[L] = rd_data lane L bit [plane].
  - Phase 1: serial_clk=1; rd_addr advances to col-1.
  - Data changes only in phase 0, so it is stable across each rising serial_clk edge.
  - Exactly COLS rising edges per plane. After the last phase 1, go to LATCH with serial_clk=0.
- LATCH (1 cycle): latch_enable=1, output_enable_n=1, row_select_n=~(1<<row).
- DISPLAY: window W = BASE_TICKS<<plane cycles; on = (W*brightness_latched)>>8.
  - output_enable_n=0 for the first `on` cycles of the window, 1 for the rest.
  - brightness 0 means output_enable_n is never low.
- BLANK (BLANK_CYCLES): output_enable_n=1.
  - On exit: plane+1. When plane wraps to 0, row+1. When row wraps to 0, frame_done pulses on the exit cycle.
  - If enable=0 at exit, go to IDLE (row_select_n=all 1, row/plane reset to 0). Otherwise go to PREP.
- Deasserting enable mid-plane has no effect until the end of BLANK; no partial planes are ever latched.
- Cycles per plane = 1 + 2*COLS + 1 + W + BLANK_CYCLES.
- Counter widths: the window counter is clog2(BASE_TICKS)+BIT_DEPTH bits; the product uses a full-width multiply before the shift (no truncation).

Decomposition:
- Shared package cube_pkg holds:
  - the scan-state enum;
  - a lane-index function (panel, color) -> L;
  - localparams for address and window widths.
- One sub-module, bcm_window_timer: takes plane, brightness_latched and start; produces on_active and window_done. It owns W, on-time and the counter.

Test Plan:
(Bench config: ROWS=2, COLS=4, BIT_DEPTH=2, BASE_TICKS=4, BLANK_CYCLES=2, NUM_PANELS=1, NUM_COLORS=3; model memory with 1-cycle latency.)
- Reset then enable=1, brightness=255 -> exactly 4 serial_clk rises per plane. output_enable_n low 3 cycles (plane 0, (4*255)>>8=3) and 7 cycles (plane 1). frame_done pulses every 72 cycles.
- Memory lane 0 = 2'b01 at col 3 only, else 0 -> serial_data_out[0] high only on the first shifted bit of plane 0, never in plane 1.
- brightness=0 -> output_enable_n stays 1 for a whole frame. latch_enable still pulses 4 times per frame.
- brightness changed 0->128 mid-frame -> current frame unchanged. The next frame shows plane-1 on-time = 4 cycles.
- enable dropped during SHIFT of row 1 -> the plane completes through BLANK, then IDLE with row_select_n=2'b11. No frame_done if not at the frame end.
- reset asserted during DISPLAY -> output_enable_n=1 and row_select_n=all 1 immediately, without waiting for a clk edge. Release with enable=1 restarts at row 0, plane 0.
